rgb_fade_seq: RTL and testbench

- Autonomous colour sequencer for the RGB PWM block. Drives its three 8-bit duty inputs (R/G/B time_in) through a fixed palette of six preset colours.
- Ramps linearly from the current colour to each preset, holds it, then advances to the next preset.
- Sits between the debounced button logic (start/stop/next pulses) and the RGB_LED PWM instance in the board top level, replacing manual ±10 brightness stepping when auto mode is selected.

---
 rtl/rgb_seq_pkg.sv | 39 +++
 rtl/rgb_fade_seq_step.sv | 33 +++
 rtl/rgb_fade_seq.sv | 148 ++++++++++++++
 tb/tb_rgb_fade_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_seq_pkg.sv
// Shared types and constants for the RGB fade sequencer.
// Holds the state encoding, colour struct and the six-entry preset palette.
package rgb_seq_pkg;

    localparam int         NUM_PRESETS = 6;
    localparam logic [7:0] DUTY_MAX    = 8'd250;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FADE = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic rgb_t preset_rgb(input logic [2:0] idx);
        rgb_t c;
        c = '0;
        case (idx)
            3'd0:    c = {DUTY_MAX, 8'd0,     8'd0};
            3'd1:    c = {DUTY_MAX, DUTY_MAX, 8'd0};
            3'd2:    c = {8'd0,     DUTY_MAX, 8'd0};
            3'd3:    c = {8'd0,     DUTY_MAX, DUTY_MAX};
            3'd4:    c = {8'd0,     8'd0,     DUTY_MAX};
            3'd5:    c = {DUTY_MAX, 8'd0,     DUTY_MAX};
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        return (idx == 3'(NUM_PRESETS - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/rgb_fade_seq_step.sv
// One channel of the linear fade: moves cur toward tgt by at most step.
// Ports: cur_i/tgt_i/step_i (8b) in; nxt_o (8b) next duty, at_tgt_o = nxt_o==tgt_i.
module fade_step (
    input  logic [7:0] cur_i,
    input  logic [7:0] tgt_i,
    input  logic [7:0] step_i,
    output logic [7:0] nxt_o,
    output logic       at_tgt_o
);

    logic [8:0] cur9;
    logic [8:0] tgt9;
    logic [8:0] step9;
    logic [8:0] diff9;

    // 9-bit compare so the distance never wraps; snapping to the target
    // when within one step prevents overshoot.
    always_comb begin
        cur9  = {1'b0, cur_i};
        tgt9  = {1'b0, tgt_i};
        step9 = {1'b0, step_i};
        diff9 = (cur9 > tgt9) ? (cur9 - tgt9) : (tgt9 - cur9);
        if (diff9 <= step9) begin
            nxt_o = tgt_i;
        end else if (cur9 > tgt9) begin
            nxt_o = cur_i - step_i;
        end else begin
            nxt_o = cur_i + step_i;
        end
        at_tgt_o = (nxt_o == tgt_i);
    end

endmodule

// File: rtl/rgb_fade_seq.sv
// Autonomous colour sequencer: fades R/G/B duties through six presets.
// Ports: clk, rst (async high), start/stop/next pulses in;
//        r/g/b_duty (8b), preset_idx (3b), busy, fade_done out (all registered).
module rgb_fade_seq
    import rgb_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 125000,
    parameter int unsigned STEP       = 10,
    parameter int unsigned HOLD_TICKS = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       next,
    output logic [7:0] r_duty,
    output logic [7:0] g_duty,
    output logic [7:0] b_duty,
    output logic [2:0] preset_idx,
    output logic       busy,
    output logic       fade_done
);

    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [7:0]    STEP_V    = 8'(STEP);

    state_e        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    rgb_t          duty_q, duty_d;
    logic [2:0]    idx_q, idx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    rgb_t       tgt;
    logic [7:0] r_nxt, g_nxt, b_nxt;
    logic [2:0] at;
    logic       running, tick, all_at, hold_last;
    logic       stop_acc, next_acc, start_acc;

    assign tgt       = preset_rgb(idx_q);
    assign running   = (state_q != ST_IDLE);
    assign tick      = running && (tick_cnt_q == TICK_LAST);
    assign all_at    = &at;
    assign hold_last = (hold_cnt_q == HOLD_LAST);

    // stop beats next and start; next beats a coincident tick
    assign stop_acc  = stop && running;
    assign next_acc  = next && running && !stop;
    assign start_acc = start && !running && !stop;

    fade_step u_r (
        .cur_i(duty_q.r), .tgt_i(tgt.r), .step_i(STEP_V),
        .nxt_o(r_nxt), .at_tgt_o(at[0])
    );
    fade_step u_g (
        .cur_i(duty_q.g), .tgt_i(tgt.g), .step_i(STEP_V),
        .nxt_o(g_nxt), .at_tgt_o(at[1])
    );
    fade_step u_b (
        .cur_i(duty_q.b), .tgt_i(tgt.b), .step_i(STEP_V),
        .nxt_o(b_nxt), .at_tgt_o(at[2])
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_acc) state_d = ST_FADE;
            end
            ST_FADE: begin
                if (stop_acc)              state_d = ST_IDLE;
                else if (next_acc)         state_d = ST_FADE;
                else if (tick && all_at)   state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (stop_acc)               state_d = ST_IDLE;
                else if (next_acc)          state_d = ST_FADE;
                else if (tick && hold_last) state_d = ST_FADE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        // tick counter wraps on a tick and idles at zero, so every
        // FADE/HOLD entry starts a full TICK_DIV period
        tick_cnt_d = '0;
        if (running && !tick) tick_cnt_d = tick_cnt_q + TW'(1);
        if (stop_acc || next_acc) tick_cnt_d = '0;
        hold_cnt_d = hold_cnt_q;
        duty_d     = duty_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
        if (next_acc) begin
            idx_d = next_idx(idx_q);
        end else if (!stop_acc && tick) begin
            if (state_q == ST_FADE) begin
                duty_d = {r_nxt, g_nxt, b_nxt};
                if (all_at) begin
                    done_d     = 1'b1;
                    hold_cnt_d = '0;
                end
            end else if (state_q == ST_HOLD) begin
                if (hold_last) idx_d = next_idx(idx_q);
                else           hold_cnt_d = hold_cnt_q + HW'(1);
            end
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
            hold_cnt_q <= '0;
            duty_q     <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            duty_q     <= duty_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign r_duty     = duty_q.r;
    assign g_duty     = duty_q.g;
    assign b_duty     = duty_q.b;
    assign preset_idx = idx_q;
    assign busy       = busy_q;
    assign fade_done  = done_q;

endmodule

// File: tb/tb_rgb_fade_seq.sv
// Bench for rgb_fade_seq: two instances (STEP 50 and 60) share stimulus,
// checked against a per-cycle behavioural model plus directed expectations.
module tb_rgb_fade_seq;

    localparam int TD = 4;
    localparam int HT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic next = 1'b0;

    logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;
    logic [2:0] idx_a, idx_b;
    logic       busy_a, busy_b, done_a, done_b;

    int n_asrt = 0;
    int n_fail = 0;

    int PAL [6][3] = '{'{250, 0, 0}, '{250, 250, 0}, '{0, 250, 0},
                       '{0, 250, 250}, '{0, 0, 250}, '{250, 0, 250}};
    int STPV [2] = '{50, 60};

    int m_du [2][3];
    int m_idx [2];
    int m_cnt [2];
    int m_hold [2];
    bit m_run [2];
    bit m_holding [2];
    bit m_done [2];

    rgb_fade_seq #(.TICK_DIV(TD), .STEP(50), .HOLD_TICKS(HT)) dut_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .next(next),
        .r_duty(r_a), .g_duty(g_a), .b_duty(b_a), .preset_idx(idx_a),
        .busy(busy_a), .fade_done(done_a)
    );

    rgb_fade_seq #(.TICK_DIV(TD), .STEP(60), .HOLD_TICKS(HT)) dut_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .next(next),
        .r_duty(r_b), .g_duty(g_b), .b_duty(b_b), .preset_idx(idx_b),
        .busy(busy_b), .fade_done(done_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 3; c++) m_du[k][c] = 0;
            m_idx[k] = 0; m_cnt[k] = 0; m_hold[k] = 0;
            m_run[k] = 0; m_holding[k] = 0; m_done[k] = 0;
        end
    endtask

    // One clock edge of the sequencer, expressed as plain arithmetic.
    task automatic model_step(input int k, input bit s, input bit p,
                              input bit n);
        int d;
        bit all;
        m_done[k] = 0;
        if (m_run[k]) begin
            if (p) begin
                m_run[k] = 0;
                m_cnt[k] = 0;
            end else if (n) begin
                m_idx[k] = (m_idx[k] + 1) % 6;
                m_holding[k] = 0;
                m_cnt[k] = 0;
            end else if (m_cnt[k] < TD - 1) begin
                m_cnt[k]++;
            end else begin
                m_cnt[k] = 0;
                if (!m_holding[k]) begin
                    all = 1;
                    for (int c = 0; c < 3; c++) begin
                        d = PAL[m_idx[k]][c] - m_du[k][c];
                        if ((d < 0 ? -d : d) <= STPV[k]) m_du[k][c] = PAL[m_idx[k]][c];
                        else if (d > 0) m_du[k][c] += STPV[k];
                        else m_du[k][c] -= STPV[k];
                        if (m_du[k][c] != PAL[m_idx[k]][c]) all = 0;
                    end
                    if (all) begin
                        m_holding[k] = 1;
                        m_hold[k] = 0;
                        m_done[k] = 1;
                    end
                end else begin
                    m_hold[k]++;
                    if (m_hold[k] == HT) begin
                        m_idx[k] = (m_idx[k] + 1) % 6;
                        m_holding[k] = 0;
                    end
                end
            end
        end else if (s && !p) begin
            m_run[k] = 1;
            m_holding[k] = 0;
            m_cnt[k] = 0;
        end
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, "_A_r"}, r_a, m_du[0][0]);
        chk({tag, "_A_g"}, g_a, m_du[0][1]);
        chk({tag, "_A_b"}, b_a, m_du[0][2]);
        chk({tag, "_A_idx"}, idx_a, m_idx[0]);
        chk({tag, "_A_busy"}, busy_a, m_run[0]);
        chk({tag, "_A_done"}, done_a, m_done[0]);
        chk({tag, "_B_r"}, r_b, m_du[1][0]);
        chk({tag, "_B_g"}, g_b, m_du[1][1]);
        chk({tag, "_B_b"}, b_b, m_du[1][2]);
        chk({tag, "_B_idx"}, idx_b, m_idx[1]);
        chk({tag, "_B_busy"}, busy_b, m_run[1]);
        chk({tag, "_B_done"}, done_b, m_done[1]);
    endtask

    task automatic cyc(input bit s, input bit p, input bit n);
        start = s; stop = p; next = n;
        @(posedge clk);
        model_step(0, s, p, n);
        model_step(1, s, p, n);
        #1;
        start = 0; stop = 0; next = 0;
        cmp_all("cyc");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        cmp_all("rst_async");
        repeat (3) @(posedge clk);
        #1;
        cmp_all("rst_hold");
        rst = 1'b0;
    endtask

    initial begin
        int seq6 [5];
        int rv;
        seq6 = '{190, 130, 70, 10, 0};
        #2;
        do_reset();

        repeat (50) cyc(0, 0, 0);
        chk("s1_r", r_a, 0);
        chk("s1_idx", idx_a, 0);
        chk("s1_busy", busy_a, 0);
        chk("s1_done", done_a, 0);

        cyc(1, 0, 0);
        chk("s2_busy", busy_a, 1);
        chk("s2_r0", r_a, 0);
        for (int k = 1; k <= 5; k++) begin
            repeat (3) cyc(0, 0, 0);
            chk("s2_r_early", r_a, 50 * (k - 1));
            cyc(0, 0, 0);
            chk("s2_r", r_a, 50 * k);
            chk("s2_g", g_a, 0);
            chk("s2_b", b_a, 0);
            chk("s2_done", done_a, (k == 5) ? 1 : 0);
        end
        cyc(0, 0, 0);
        chk("s2_done_clr", done_a, 0);

        repeat (10) cyc(0, 0, 0);
        chk("s3_idx_hold", idx_a, 0);
        cyc(0, 0, 0);
        chk("s3_idx", idx_a, 1);
        repeat (4) cyc(0, 0, 0);
        chk("s3_g50", g_a, 50);
        repeat (4) cyc(0, 0, 0);
        chk("s3_g100", g_a, 100);
        chk("s3_r", r_a, 250);

        cyc(0, 0, 1);
        chk("s4_idx", idx_a, 2);
        repeat (3) cyc(0, 0, 0);
        chk("s4_g_wait", g_a, 100);
        cyc(0, 0, 0);
        chk("s4_r", r_a, 200);
        chk("s4_g", g_a, 150);

        cyc(0, 1, 0);
        chk("s5_busy", busy_a, 0);
        repeat (40) cyc(0, 0, 0);
        chk("s5_frz_g", g_a, 150);
        chk("s5_frz_r", r_a, 200);
        chk("s5_frz_idx", idx_a, 2);
        cyc(1, 0, 0);
        chk("s5_busy_on", busy_a, 1);
        repeat (3) cyc(0, 0, 0);
        chk("s5_g_wait", g_a, 150);
        cyc(0, 0, 0);
        chk("s5_g200", g_a, 200);
        chk("s5_r150", r_a, 150);
        repeat (4) cyc(0, 0, 0);
        chk("s5_g250", g_a, 250);
        repeat (8) cyc(0, 0, 0);
        chk("s5_r0", r_a, 0);
        chk("s5_done", done_a, 1);

        do_reset();
        cyc(1, 0, 0);
        repeat (4) cyc(0, 0, 1);
        chk("s6_idx4", idx_b, 4);
        for (int i = 0; i < 400 && idx_b != 3'd0; i++) cyc(0, 0, 0);
        chk("s6_wrap", idx_b, 0);
        chk("s6_b250", b_b, 250);
        chk("s6_r250", r_b, 250);
        for (int j = 0; j < 5; j++) begin
            repeat (4) cyc(0, 0, 0);
            chk("s6_b", b_b, seq6[j]);
        end
        chk("s6_done", done_b, 1);
        chk("s6_r", r_b, 250);
        cyc(0, 1, 1);
        chk("s6_stopnext_busy", busy_b, 0);
        chk("s6_stopnext_idx", idx_b, 0);

        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rv = $urandom_range(0, 999);
            if (rv < 3) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 19) == 0,
                    $urandom_range(0, 59) == 0,
                    $urandom_range(0, 29) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
